// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch
//  Purpose  : Fetch stage feeding the main decoder/controller. Owns the
//             program counter, handshakes with a variable-latency instruction
//             memory, registers the returned word and presents it (plus its
//             decoded fields) downstream. The next PC is PC+4 or the branch
//             target, as selected by the decoder's branch condition.
//  Ports    : i_clk, i_rst_n              clock / async active-low reset
//             o_imemReq, o_imemAddr       fetch request and address (= PC)
//             i_imemAck, i_imemRdata      memory response
//             i_stall                     downstream hold of the current instr
//             i_branchCondition/Target    next-PC selection from the decoder
//             o_instrValid, o_instr, o_pc presented instruction and its PC
//             o_operand/funct3/funct7bit5 field slices of o_instr
//             o_instrCount                retired-instruction counter
//             o_misalignedErr             sticky misaligned-taken-target flag
//  Revision : 1.0  initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imemReq,
    output logic [31:0] o_imemAddr,
    input  logic        i_imemAck,
    input  logic [31:0] i_imemRdata,
    input  logic        i_stall,
    input  logic        i_branchCondition,
    input  logic [31:0] i_branchTarget,
    output logic        o_instrValid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [6:0]  o_operand,
    output logic [2:0]  o_funct3,
    output logic        o_funct7bit5,
    output logic [31:0] o_instrCount,
    output logic        o_misalignedErr
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_EXEC = 2'b10
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] count_q;
    logic        req_q;
    logic        valid_q;
    logic        err_q;
    logic        w_misaligned;

    // Taken targets are word-aligned by dropping the low bits; the error flag
    // only fires when the branch is actually taken.
    assign pc_d         = i_branchCondition ? {i_branchTarget[31:2], 2'b00}
                                            : pc_q + 32'd4;
    assign w_misaligned = i_branchCondition && (i_branchTarget[1:0] != 2'b00);

    // Single FSM block; request/valid are registered alongside the state so
    // they change exactly with it (and drop at once on async reset).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            count_q <= 32'd0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                    req_q   <= 1'b1;
                end
                S_REQ: begin
                    if (i_imemAck) begin
                        instr_q <= i_imemRdata;
                        state_q <= S_EXEC;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // Retire: branch inputs are sampled only on this edge.
                    if (!i_stall) begin
                        pc_q    <= pc_d;
                        count_q <= count_q + 32'd1;
                        if (w_misaligned) begin
                            err_q <= 1'b1;
                        end
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_imemReq       = req_q;
    assign o_imemAddr      = pc_q;
    assign o_pc            = pc_q;
    assign o_instrValid    = valid_q;
    assign o_instr         = instr_q;
    assign o_operand       = instr_q[6:0];
    assign o_funct3        = instr_q[14:12];
    assign o_funct7bit5    = instr_q[30];
    assign o_instrCount    = count_q;
    assign o_misalignedErr = err_q;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instruction_fetch
//  Purpose  : Directed self-checking bench for instruction_fetch. A
//             transaction-level model (waiting-for-memory / holding-an-
//             instruction flags, PC and counter arithmetic) is compared with
//             every DUT output on each falling edge; literal expectations at
//             chosen points pin the model itself.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic        bc;
    logic [31:0] bt;

    logic        o_imemReq;
    logic [31:0] o_imemAddr;
    logic        o_instrValid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic [6:0]  o_operand;
    logic [2:0]  o_funct3;
    logic        o_funct7bit5;
    logic [31:0] o_instrCount;
    logic        o_misalignedErr;

    int n_total = 0;
    int n_pass  = 0;

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .o_imemReq         (o_imemReq),
        .o_imemAddr        (o_imemAddr),
        .i_imemAck         (ack),
        .i_imemRdata       (rdata),
        .i_stall           (stall),
        .i_branchCondition (bc),
        .i_branchTarget    (bt),
        .o_instrValid      (o_instrValid),
        .o_instr           (o_instr),
        .o_pc              (o_pc),
        .o_operand         (o_operand),
        .o_funct3          (o_funct3),
        .o_funct7bit5      (o_funct7bit5),
        .o_instrCount      (o_instrCount),
        .o_misalignedErr   (o_misalignedErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: "started" marks the idle cycle after reset,
    // "waiting" means a fetch is outstanding, "holding" means an
    // instruction is presented and not yet retired.
    // ------------------------------------------------------------------
    logic        m_started;
    logic        m_waiting;
    logic        m_holding;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_count;
    logic        m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_waiting <= 1'b0;
            m_holding <= 1'b0;
            m_pc      <= 32'h0;
            m_instr   <= 32'h0000_0013;
            m_count   <= 32'h0;
            m_err     <= 1'b0;
        end else if (!m_started) begin
            m_started <= 1'b1;
            m_waiting <= 1'b1;
        end else if (m_waiting && ack) begin
            m_instr   <= rdata;
            m_waiting <= 1'b0;
            m_holding <= 1'b1;
        end else if (m_holding && !stall) begin
            m_pc      <= bc ? (bt & 32'hFFFF_FFFC) : m_pc + 32'd4;
            m_count   <= m_count + 32'd1;
            m_err     <= m_err | (bc && (bt % 4 != 0));
            m_holding <= 1'b0;
            m_waiting <= 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("req",     {31'd0, o_imemReq},       {31'd0, m_waiting});
        chk("addr",    o_imemAddr,               m_pc);
        chk("pc",      o_pc,                     m_pc);
        chk("valid",   {31'd0, o_instrValid},    {31'd0, m_holding});
        chk("instr",   o_instr,                  m_instr);
        chk("operand", {25'd0, o_operand},       {25'd0, m_instr[6:0]});
        chk("funct3",  {29'd0, o_funct3},        {29'd0, m_instr[14:12]});
        chk("f7b5",    {31'd0, o_funct7bit5},    {31'd0, m_instr[30]});
        chk("count",   o_instrCount,             m_count);
        chk("err",     {31'd0, o_misalignedErr}, {31'd0, m_err});
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Call with the DUT requesting; leaves it presenting `word`, with the
    // ack line still high and garbage on rdata (both must be ignored).
    task automatic fetch(input int waits, input logic [31:0] word, input logic [31:0] addr);
        for (int i = 0; i < waits; i++) begin
            ack   = 1'b0;
            stall = 1'b1;
            rdata = 32'hBAD0_0000 | i;
            step();
            chk("wait_req",   {31'd0, o_imemReq},    32'd1);
            chk("wait_addr",  o_imemAddr,            addr);
            chk("wait_valid", {31'd0, o_instrValid}, 32'd0);
        end
        stall = 1'b0;
        ack   = 1'b1;
        rdata = word;
        step();
        chk("ack_valid", {31'd0, o_instrValid}, 32'd1);
        chk("ack_instr", o_instr,               word);
        ack   = 1'b1;
        rdata = ~word;
    endtask

    // Stall for n cycles (random branch inputs meanwhile), then retire.
    task automatic exec(input int n, input logic c, input logic [31:0] t,
                        input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
        for (int i = 0; i < n; i++) begin
            stall = 1'b1;
            bc    = 1'($urandom_range(0, 1));
            bt    = $urandom;
            step();
            chk("stall_pc",    o_pc,                  exp_pc);
            chk("stall_cnt",   o_instrCount,          exp_cnt);
            chk("stall_req",   {31'd0, o_imemReq},    32'd0);
            chk("stall_valid", {31'd0, o_instrValid}, 32'd1);
        end
        stall = 1'b0;
        bc    = c;
        bt    = t;
        step();
        ack   = 1'b0;
        bc    = 1'b0;
        bt    = 32'h0;
        chk("retire_cnt", o_instrCount, exp_cnt + 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ack   = 1'b0;
        rdata = 32'h0;
        stall = 1'b0;
        bc    = 1'b0;
        bt    = 32'h0;
        repeat (3) step();
        chk("rst_req",   {31'd0, o_imemReq},    32'd0);
        chk("rst_valid", {31'd0, o_instrValid}, 32'd0);
        chk("rst_pc",    o_pc,                  32'h0);
        chk("rst_instr", o_instr,               32'h0000_0013);
        chk("rst_cnt",   o_instrCount,          32'd0);

        rst_n = 1'b1;
        step();
        chk("first_req", {31'd0, o_imemReq}, 32'd1);

        // zero-wait fetch at 0
        fetch(0, 32'h0050_0093, 32'h0);
        chk("op0", {25'd0, o_operand}, 32'h13);
        chk("pc0", o_pc, 32'h0);
        exec(0, 1'b0, 32'h0, 32'h0, 32'd0);
        chk("addr4", o_imemAddr, 32'h4);

        // three wait states at 4 (stall asserted meanwhile, no effect)
        fetch(3, 32'h0020_81B3, 32'h4);
        chk("op1", {25'd0, o_operand}, 32'h33);
        exec(0, 1'b0, 32'h0, 32'h4, 32'd1);
        chk("addr8", o_imemAddr, 32'h8);

        // stall 4 cycles at 8, then taken branch to 0x40
        fetch(1, 32'h4020_C463, 32'h8);
        chk("f3",   {29'd0, o_funct3},     32'd4);
        chk("f7b5", {31'd0, o_funct7bit5}, 32'd1);
        exec(4, 1'b1, 32'h40, 32'h8, 32'd2);
        chk("addr40", o_imemAddr, 32'h40);

        // not-taken with misaligned target -> 0x44, no error
        fetch(0, 32'h00A0_0113, 32'h40);
        exec(0, 1'b0, 32'h43, 32'h40, 32'd3);
        chk("addr44", o_imemAddr, 32'h44);
        chk("err0",   {31'd0, o_misalignedErr}, 32'd0);

        // taken misaligned target 0x42 -> 0x40, sticky error
        fetch(2, 32'h0000_0063, 32'h44);
        exec(0, 1'b1, 32'h42, 32'h44, 32'd4);
        chk("addr40b", o_imemAddr, 32'h40);
        chk("err1",    {31'd0, o_misalignedErr}, 32'd1);

        // PC wrap
        fetch(0, 32'h0000_0013, 32'h40);
        exec(0, 1'b1, 32'hFFFF_FFFC, 32'h40, 32'd5);
        chk("addrTop", o_imemAddr, 32'hFFFF_FFFC);
        fetch(0, 32'h0000_0013, 32'hFFFF_FFFC);
        exec(0, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'd6);
        chk("addrWrap", o_imemAddr, 32'h0);
        chk("cnt7",     o_instrCount, 32'd7);
        chk("errStick", {31'd0, o_misalignedErr}, 32'd1);

        // async reset mid-wait
        ack = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, o_imemReq},       32'd0);
        chk("arst_err", {31'd0, o_misalignedErr}, 32'd0);
        chk("arst_cnt", o_instrCount,             32'd0);
        ack   = 1'b1;
        rdata = 32'hDEAD_BEEF;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("late_req",   {31'd0, o_imemReq},    32'd1);
        chk("late_valid", {31'd0, o_instrValid}, 32'd0);
        chk("late_instr", o_instr,               32'h0000_0013);
        ack = 1'b0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
